// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM answering CPU readM/writeM with latency and a four-phase handshake
module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic                 busy,
  output logic                 protocol_err
);
  localparam int LMAX = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW = $clog2(LMAX + 1);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_ACK, WR_WAIT, WR_ACK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [ADDR_BITS-1:0] idx, wa;
  logic [WORD_SIZE-1:0] wdata, rdata, wd;
  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];
  logic we, err, unused_hi;
  assign unused_hi = ^address[WORD_SIZE-1:ADDR_BITS];
  assign busy = state != IDLE;
  assign data = inputReady ? rdata : {WORD_SIZE{1'bz}};
  assign err = (state == IDLE && writeM && readM) || (load_en && (state != IDLE || readM || writeM));
  // Backdoor loads share the RAM port with write commits; they can only happen in IDLE.
  assign we = reset_n && ((state == WR_WAIT && cnt == '0) || (state == IDLE && load_en && !readM && !writeM));
  assign wa = state == IDLE ? load_addr : idx;
  assign wd = state == IDLE ? load_data : wdata;
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      inputReady <= 1'b0;
      ackOutput <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= protocol_err | err;
      case (state)
        IDLE:
          if (writeM) begin
            idx <= address[ADDR_BITS-1:0];
            wdata <= data;
            cnt <= CW'(WRITE_LAT - 1);
            state <= WR_WAIT;
          end else if (readM) begin
            idx <= address[ADDR_BITS-1:0];
            cnt <= CW'(READ_LAT - 1);
            state <= RD_WAIT;
          end
        RD_WAIT:
          if (cnt == '0) begin
            rdata <= mem[idx];
            inputReady <= 1'b1;
            state <= RD_ACK;
          end else cnt <= cnt - 1'b1;
        RD_ACK:
          if (!readM) begin
            inputReady <= 1'b0;
            state <= IDLE;
          end
        WR_WAIT:
          if (cnt == '0) begin
            ackOutput <= 1'b1;
            state <= WR_ACK;
          end else cnt <= cnt - 1'b1;
        WR_ACK:
          if (!writeM) begin
            ackOutput <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed CPU transactions checked against a transaction-level memory model
module tb_mem_responder;
  localparam int W = 16, A = 8, RL = 2, WL = 2;
  logic clk = 0, reset_n = 0, readM = 0, writeM = 0, load_en = 0, cpu_oe = 0;
  logic [W-1:0] address = '0, cpu_d = '0, load_data = '0;
  logic [A-1:0] load_addr = '0;
  wire  [W-1:0] data;
  logic inputReady, ackOutput, busy, protocol_err;
  int tests = 0, fails = 0;
  assign data = cpu_oe ? cpu_d : 'z;
  always #5 clk = ~clk;
  mem_responder #(.WORD_SIZE(W), .ADDR_BITS(A), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM), .address(address),
    .data(data), .inputReady(inputReady), .ackOutput(ackOutput), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy), .protocol_err(protocol_err)
  );
  int pend, age;
  bit started = 0;
  logic m_ir, m_ack, m_err;
  logic [A-1:0] m_idx;
  logic [W-1:0] m_rd, m_wd;
  logic [W-1:0] mmem [256];
  // pend: 0 none, 1 read, 2 write; age counts edges since acceptance
  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset_n) begin
      pend <= 0; age <= 0; m_ir <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
    end else if (pend == 0) begin
      if (writeM) begin
        pend <= 2; age <= 0; m_idx <= address[A-1:0]; m_wd <= data;
        if (readM || load_en) m_err <= 1'b1;
      end else if (readM) begin
        pend <= 1; age <= 0; m_idx <= address[A-1:0];
        if (load_en) m_err <= 1'b1;
      end else if (load_en) mmem[load_addr] <= load_data;
    end else begin
      age <= age + 1;
      if (load_en) m_err <= 1'b1;
      if (pend == 1) begin
        if (m_ir) begin
          if (!readM) begin pend <= 0; m_ir <= 1'b0; end
        end else if (age + 1 == RL) begin
          m_ir <= 1'b1; m_rd <= mmem[m_idx];
        end
      end else begin
        if (m_ack) begin
          if (!writeM) begin pend <= 0; m_ack <= 1'b0; end
        end else if (age + 1 == WL) begin
          m_ack <= 1'b1; mmem[m_idx] <= m_wd;
        end
      end
    end
  end
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (started) begin
      check("inputReady", W'(inputReady), W'(m_ir));
      check("ackOutput", W'(ackOutput), W'(m_ack));
      check("busy", W'(busy), W'(pend != 0));
      check("protocol_err", W'(protocol_err), W'(m_err));
      if (m_ir) check("data", data, m_rd);
    end
  task automatic load(input logic [A-1:0] a, input logic [W-1:0] d);
    @(negedge clk); load_en = 1; load_addr = a; load_data = d;
    @(negedge clk); load_en = 0;
  endtask
  task automatic do_read(input logic [W-1:0] a, input logic [W-1:0] exp, input int hold);
    int n = 0;
    @(negedge clk); address = a; readM = 1;
    do begin @(negedge clk); n++; end while (!inputReady && n < 20);
    check("rd_latency", W'(n), W'(RL + 1));
    check("rd_data", data, exp);
    repeat (hold) begin
      @(negedge clk);
      check("rd_hold_ir", W'(inputReady), W'(1));
      check("rd_hold_data", data, exp);
    end
    readM = 0;
    @(negedge clk);
    check("rd_release", W'(inputReady), W'(0));
    check("rd_idle", W'(busy), W'(0));
  endtask
  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d, input logic both);
    int n = 0;
    @(negedge clk); address = a; cpu_d = d; cpu_oe = 1; writeM = 1; readM = both;
    do begin @(negedge clk); n++; end while (!ackOutput && n < 20);
    check("wr_latency", W'(n), W'(WL + 1));
    writeM = 0; readM = 0; cpu_oe = 0;
    @(negedge clk);
    check("wr_release", W'(ackOutput), W'(0));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ir", W'(inputReady), W'(0));
    check("rst_ack", W'(ackOutput), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_err", W'(protocol_err), W'(0));
    reset_n = 1;
    load(8'h03, 16'h7A21);
    do_read(16'h0003, 16'h7A21, 0);
    do_write(16'h0010, 16'hBEEF, 0);
    do_read(16'h0010, 16'hBEEF, 0);
    do_write(16'h0105, 16'h1234, 0);
    do_read(16'h0005, 16'h1234, 0);
    check("err_before", W'(protocol_err), W'(0));
    do_write(16'h0020, 16'h00FF, 1);
    check("err_after", W'(protocol_err), W'(1));
    do_read(16'h0020, 16'h00FF, 0);
    load(8'h04, 16'h5555);
    @(negedge clk); address = 16'h0004; cpu_d = 16'hAAAA; cpu_oe = 1; writeM = 1;
    @(negedge clk); reset_n = 0; writeM = 0; cpu_oe = 0;
    @(negedge clk); reset_n = 1;
    check("rst_mid_ack", W'(ackOutput), W'(0));
    check("rst_mid_busy", W'(busy), W'(0));
    check("rst_mid_err", W'(protocol_err), W'(0));
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ack", W'(ackOutput), W'(0));
    end
    do_read(16'h0004, 16'h5555, 0);
    do_read(16'h0003, 16'h7A21, 5);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
